// File: rtl/fifo_pkg.sv
// Shared types and default constants for the parametrised FIFO.
package fifo_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    WR_RD    = 3'd4,
    WR_ERROR = 3'd5,
    RD_ERROR = 3'd6
  } fifo_state_e;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_AE_LEVEL   = 2;

endpackage

// File: rtl/fifo_ns_cal.sv
// Combinational next-state, next-pointer, next-count and write/read-enable
// calculator for fifo_param.
module fifo_ns_cal
  import fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [ADDR_WIDTH-1:0] head,
  input  logic [ADDR_WIDTH-1:0] tail,
  output fifo_state_e           next_state,
  output logic [ADDR_WIDTH-1:0] next_head,
  output logic [ADDR_WIDTH-1:0] next_tail,
  output logic [ADDR_WIDTH:0]   next_count,
  output logic                  we,
  output logic                  re,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic is_full;
  logic is_empty;

  assign is_full  = (count == FULL_COUNT);
  assign is_empty = (count == '0);

  always_comb begin
    next_state = NO_OP;
    we         = 1'b0;
    re         = 1'b0;
    wr_ack     = 1'b0;
    wr_err     = 1'b0;
    rd_ack     = 1'b0;
    rd_err     = 1'b0;
    case ({wr_en, rd_en})
      2'b10: begin
        if (is_full) begin
          next_state = WR_ERROR;
          wr_err     = 1'b1;
        end else begin
          next_state = WRITE;
          we         = 1'b1;
          wr_ack     = 1'b1;
        end
      end
      2'b01: begin
        if (is_empty) begin
          next_state = RD_ERROR;
          rd_err     = 1'b1;
        end else begin
          next_state = READ;
          re         = 1'b1;
          rd_ack     = 1'b1;
        end
      end
      2'b11: begin
        // When full, both proceed: the read frees the slot the write lands in.
        if (is_empty) begin
          next_state = RD_ERROR;
          we         = 1'b1;
          wr_ack     = 1'b1;
          rd_err     = 1'b1;
        end else begin
          next_state = WR_RD;
          we         = 1'b1;
          re         = 1'b1;
          wr_ack     = 1'b1;
          rd_ack     = 1'b1;
        end
      end
      default: next_state = NO_OP;
    endcase
  end

  always_comb begin
    next_head  = head;
    next_tail  = tail;
    next_count = count;
    if (we) next_tail = tail + 1'b1;
    if (re) next_head = head + 1'b1;
    if (we && !re) next_count = count + 1'b1;
    if (re && !we) next_count = count - 1'b1;
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with simultaneous read/write support.
// Optional almost-full/almost-empty flags are enabled by FIFO_ALMOST_FLAGS_EN.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = FIFO_AE_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output fifo_state_e           dbg_state
);

  // Handshake: wr_en/rd_en are requests sampled on each rising edge; on the
  // following cycle exactly one of wr_ack/wr_err (rd_ack/rd_err) pulses for
  // each request, and no pulse appears for a cycle without a request.

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH-1:0] next_head;
  logic [ADDR_WIDTH-1:0] next_tail;
  logic [ADDR_WIDTH:0]   next_count;
  fifo_state_e           state;
  fifo_state_e           next_state;
  logic                  we;
  logic                  re;
  logic                  nx_wr_ack;
  logic                  nx_wr_err;
  logic                  nx_rd_ack;
  logic                  nx_rd_err;

  fifo_ns_cal #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ns_cal (
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .count      (data_count),
    .head       (head),
    .tail       (tail),
    .next_state (next_state),
    .next_head  (next_head),
    .next_tail  (next_tail),
    .next_count (next_count),
    .we         (we),
    .re         (re),
    .wr_ack     (nx_wr_ack),
    .wr_err     (nx_wr_err),
    .rd_ack     (nx_rd_ack),
    .rd_err     (nx_rd_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state      <= next_state;
      head       <= next_head;
      tail       <= next_tail;
      data_count <= next_count;
      wr_ack     <= nx_wr_ack;
      wr_err     <= nx_wr_err;
      rd_ack     <= nx_rd_ack;
      rd_err     <= nx_rd_err;
      if (re) dout <= mem[head];
    end
  end

  // Storage is not reset; after reset the pointers make old entries unreachable.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[tail] <= din;
  end

  assign full      = (data_count == FULL_COUNT);
  assign empty     = (data_count == '0);
  assign dbg_state = state;

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_COUNT = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_COUNT = (ADDR_WIDTH + 1)'(AE_LEVEL);

  assign almost_full  = (data_count >= AF_COUNT);
  assign almost_empty = (data_count <= AE_COUNT);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed boundary sequences followed by
// random traffic, all checked against a queue-based reference model.
module tb_fifo_param;
  import fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   data_count;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
  fifo_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: stored entries plus what the last cycle should show.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout;
  fifo_state_e   exp_state;
  logic          exp_wr_ack, exp_wr_err, exp_rd_ack, exp_rd_err;

  fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = exp_q.size();
    check_eq({ctx, " dout"},       dout, exp_dout);
    check_eq({ctx, " data_count"}, DW'(data_count), DW'(n));
    check_eq({ctx, " full"},       DW'(full), DW'(n == DEPTH));
    check_eq({ctx, " empty"},      DW'(empty), DW'(n == 0));
    check_eq({ctx, " wr_ack"},     DW'(wr_ack), DW'(exp_wr_ack));
    check_eq({ctx, " wr_err"},     DW'(wr_err), DW'(exp_wr_err));
    check_eq({ctx, " rd_ack"},     DW'(rd_ack), DW'(exp_rd_ack));
    check_eq({ctx, " rd_err"},     DW'(rd_err), DW'(exp_rd_err));
    check_eq({ctx, " state"},      DW'(dbg_state), DW'(exp_state));
`ifdef FIFO_ALMOST_FLAGS_EN
    check_eq({ctx, " almost_full"},  DW'(almost_full), DW'(n >= AF));
    check_eq({ctx, " almost_empty"}, DW'(almost_empty), DW'(n <= AE));
`else
    check_eq({ctx, " almost_full"},  DW'(almost_full), '0);
    check_eq({ctx, " almost_empty"}, DW'(almost_empty), '0);
`endif
  endtask

  // Model update from the request and the pre-edge occupancy.
  task automatic model_cycle(input logic w, input logic r, input logic [DW-1:0] d);
    int n;
    n = exp_q.size();
    exp_wr_ack = 1'b0;
    exp_wr_err = 1'b0;
    exp_rd_ack = 1'b0;
    exp_rd_err = 1'b0;
    if (w && r) begin
      if (n == 0) begin
        exp_q.push_back(d);
        exp_wr_ack = 1'b1;
        exp_rd_err = 1'b1;
        exp_state  = RD_ERROR;
      end else begin
        exp_dout = exp_q.pop_front();
        exp_q.push_back(d);
        exp_wr_ack = 1'b1;
        exp_rd_ack = 1'b1;
        exp_state  = WR_RD;
      end
    end else if (w) begin
      if (n == DEPTH) begin
        exp_wr_err = 1'b1;
        exp_state  = WR_ERROR;
      end else begin
        exp_q.push_back(d);
        exp_wr_ack = 1'b1;
        exp_state  = WRITE;
      end
    end else if (r) begin
      if (n == 0) begin
        exp_rd_err = 1'b1;
        exp_state  = RD_ERROR;
      end else begin
        exp_dout   = exp_q.pop_front();
        exp_rd_ack = 1'b1;
        exp_state  = READ;
      end
    end else begin
      exp_state = NO_OP;
    end
  endtask

  // Driver tasks
  task automatic step(input string ctx, input logic w, input logic r, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    model_cycle(w, r, d);
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx, input logic w, input logic r);
    @(negedge clk);
    reset = 1'b1;
    wr_en = w;
    rd_en = r;
    din   = $urandom;
    @(posedge clk);
    exp_q.delete();
    exp_dout   = '0;
    exp_state  = INIT;
    exp_wr_ack = 1'b0;
    exp_wr_err = 1'b0;
    exp_rd_ack = 1'b0;
    exp_rd_err = 1'b0;
    #1;
    check_all(ctx);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    do_reset("reset", 1'b0, 1'b0);
    step("idle", 1'b0, 1'b0, '0);

    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, DW'(i * 'h11));
    step("overflow", 1'b1, 1'b0, 'h99);

    for (int i = 0; i < 9; i++) step("drain", 1'b0, 1'b1, '0);

    step("both_empty", 1'b1, 1'b1, 'hAB);
    step("drain1", 1'b0, 1'b1, '0);

    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 1'b0, $urandom);
    step("both_full", 1'b1, 1'b1, 'hCAFE);
    for (int i = 0; i < DEPTH; i++) step("drain_full", 1'b0, 1'b1, '0);

    for (int i = 0; i < 3; i++) step("prime", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'b1, $urandom);
    for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, 1'b1, '0);

    for (int i = 0; i < 5; i++) step("pre_reset", 1'b1, 1'b0, $urandom);
    do_reset("mid_reset", 1'b1, 1'b1);
    step("post_reset", 1'b0, 1'b1, '0);

    for (int i = 0; i < 400; i++) begin
      logic w, r;
      // Bias toward writes early and reads later to visit both boundaries.
      w = ($urandom_range(0, 99) < ((i < 200) ? 65 : 35));
      r = ($urandom_range(0, 99) < ((i < 200) ? 35 : 65));
      step("random", w, r, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
